// File: rtl/traffic_phase_arbiter.sv
// Actuated NS/EW/pedestrian intersection controller with min/max green, yellow and all-red timing.
// Optional PED_COUNTDOWN_EN adds a ped_count walk-countdown output.
module traffic_phase_arbiter #(
  parameter int unsigned MIN_GREEN    = 10,
  parameter int unsigned MAX_GREEN    = 30,
  parameter int unsigned YELLOW_TIME  = 5,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned WALK_TIME    = 8,
  parameter int unsigned TW           = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ns_req,
  input  logic          ew_req,
  input  logic          ped_req,
  output logic          ns_red,
  output logic          ns_yellow,
  output logic          ns_green,
  output logic          ew_red,
  output logic          ew_yellow,
  output logic          ew_green,
  output logic          walk,
  output logic [2:0]    phase,
  output logic          ped_pending
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [TW-1:0] ped_count
`endif
);

  typedef enum logic [2:0] {
    StNsGreen  = 3'd0,
    StNsYellow = 3'd1,
    StAllRed1  = 3'd2,
    StEwGreen  = 3'd3,
    StEwYellow = 3'd4,
    StAllRed2  = 3'd5,
    StPedWalk  = 3'd6
  } state_e;

  localparam logic          DirNs      = 1'b0;
  localparam logic          DirEw      = 1'b1;
  localparam logic [TW-1:0] MinGreenM1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MaxGreenM1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YellowM1   = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AllRedM1   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] WalkM1     = TW'(WALK_TIME - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_q, ped_d;
  logic          dir_q, dir_d;
  logic          in_green;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StNsGreen;
      timer_q <= '0;
      ped_q   <= 1'b0;
      dir_q   <= DirEw;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    in_green = (state_q == StNsGreen) || (state_q == StEwGreen);
    case (state_q)
      StNsGreen: begin
        if ((timer_q >= MinGreenM1) && (ew_req || ped_q) &&
            (!ns_req || (timer_q == MaxGreenM1))) begin
          state_d = StNsYellow;
        end
      end
      StNsYellow: if (timer_q == YellowM1) state_d = StAllRed1;
      StAllRed1: begin
        if (timer_q == AllRedM1) begin
          if (ped_q) begin
            state_d = StPedWalk;
            dir_d   = DirEw;
          end else begin
            state_d = StEwGreen;
          end
        end
      end
      StEwGreen: begin
        if ((timer_q >= MinGreenM1) && (ns_req || ped_q) &&
            (!ew_req || (timer_q == MaxGreenM1))) begin
          state_d = StEwYellow;
        end
      end
      StEwYellow: if (timer_q == YellowM1) state_d = StAllRed2;
      StAllRed2: begin
        if (timer_q == AllRedM1) begin
          if (ped_q) begin
            state_d = StPedWalk;
            dir_d   = DirNs;
          end else begin
            state_d = StNsGreen;
          end
        end
      end
      StPedWalk: begin
        if (timer_q == WalkM1) state_d = (dir_q == DirEw) ? StEwGreen : StNsGreen;
      end
      default: state_d = StNsGreen;
    endcase

    // Green timers hold at MAX_GREEN-1 so a late competing request still sees the max-out condition.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (in_green && (timer_q == MaxGreenM1)) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    ped_d = ped_q;
    if ((state_d == StPedWalk) && (state_q != StPedWalk)) begin
      ped_d = 1'b0;
    end else if (ped_req && (state_q != StPedWalk)) begin
      ped_d = 1'b1;
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (state_q)
      StNsGreen: begin
        ns_red   = 1'b0;
        ns_green = 1'b1;
      end
      StNsYellow: begin
        ns_red    = 1'b0;
        ns_yellow = 1'b1;
      end
      StEwGreen: begin
        ew_red   = 1'b0;
        ew_green = 1'b1;
      end
      StEwYellow: begin
        ew_red    = 1'b0;
        ew_yellow = 1'b1;
      end
      StPedWalk: walk = 1'b1;
      default: ;
    endcase
  end

  assign phase       = state_q;
  assign ped_pending = ped_q;

`ifdef PED_COUNTDOWN_EN
  assign ped_count = (state_q == StPedWalk) ? (WalkM1 - timer_q) : '0;
`endif

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Self-checking bench for traffic_phase_arbiter: directed plan steps plus randomized traffic
// checked every cycle against a phase/elapsed-time reference model.
module tb_traffic_phase_arbiter;

  localparam int MIN  = 10;
  localparam int MAX  = 30;
  localparam int YEL  = 5;
  localparam int AR   = 2;
  localparam int WLK  = 8;
  localparam int TW   = 6;

  logic       clk;
  logic       reset;
  logic       ns_req, ew_req, ped_req;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;
`ifdef PED_COUNTDOWN_EN
  logic [TW-1:0] ped_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, unbounded cycles elapsed in phase, ped latch, post-walk dir.
  int m_phase;
  int m_el;
  bit m_ped;
  bit m_dir;   // 1 = EW

  traffic_phase_arbiter #(
    .MIN_GREEN    (MIN),
    .MAX_GREEN    (MAX),
    .YELLOW_TIME  (YEL),
    .ALL_RED_TIME (AR),
    .WALK_TIME    (WLK),
    .TW           (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ns_req      (ns_req),
    .ew_req      (ew_req),
    .ped_req     (ped_req),
    .ns_red      (ns_red),
    .ns_yellow   (ns_yellow),
    .ns_green    (ns_green),
    .ew_red      (ew_red),
    .ew_yellow   (ew_yellow),
    .ew_green    (ew_green),
    .walk        (walk),
    .phase       (phase),
    .ped_pending (ped_pending)
`ifdef PED_COUNTDOWN_EN
    ,
    .ped_count   (ped_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] lamps(input int p);
    case (p)
      0:       return 7'b0011000;
      1:       return 7'b0101000;
      3:       return 7'b1000010;
      4:       return 7'b1000100;
      6:       return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  task automatic model_edge();
    int  np;
    bit  own, comp;
    if (!reset) begin
      m_phase = 0;
      m_el    = 0;
      m_ped   = 1'b0;
      m_dir   = 1'b1;
      return;
    end
    np = m_phase;
    case (m_phase)
      0, 3: begin
        own  = (m_phase == 0) ? ns_req : ew_req;
        comp = ((m_phase == 0) ? ew_req : ns_req) | m_ped;
        if (m_el >= MIN - 1 && comp && (!own || m_el >= MAX - 1)) np = m_phase + 1;
      end
      1, 4: if (m_el == YEL - 1) np = m_phase + 1;
      2, 5: begin
        if (m_el == AR - 1) begin
          if (m_ped) begin
            np    = 6;
            m_dir = (m_phase == 2);
          end else begin
            np = (m_phase == 2) ? 3 : 0;
          end
        end
      end
      default: if (m_el == WLK - 1) np = m_dir ? 3 : 0;
    endcase
    if (np == 6 && m_phase != 6) m_ped = 1'b0;
    else if (ped_req && m_phase != 6) m_ped = 1'b1;
    m_el    = (np != m_phase) ? 0 : m_el + 1;
    m_phase = np;
  endtask

  task automatic compare_all();
    int exp_timer;
    exp_timer = ((m_phase == 0 || m_phase == 3) && m_el > MAX - 1) ? MAX - 1 : m_el;
    check("phase", 32'(phase), 32'(m_phase));
    check("lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}),
          32'(lamps(m_phase)));
    check("ped_pending", 32'(ped_pending), 32'(m_ped));
    check("timer", 32'(dut.timer_q), 32'(exp_timer));
    check("dual_green", 32'(ns_green & ew_green), 32'd0);
    check("walk_reds", 32'(walk & ~(ns_red & ew_red)), 32'd0);
    check("ns_one_lamp", 32'($countones({ns_red, ns_yellow, ns_green})), 32'd1);
    check("ew_one_lamp", 32'($countones({ew_red, ew_yellow, ew_green})), 32'd1);
`ifdef PED_COUNTDOWN_EN
    check("ped_count", 32'(ped_count), (m_phase == 6) ? 32'(WLK - 1 - m_el) : 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) step();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    ns_req  = 1'b0;
    ew_req  = 1'b0;
    ped_req = 1'b0;

    // Reset for 3 cycles with no requests.
    do_reset(3);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ns_green", 32'(ns_green), 32'd1);
    check("rst_ew_red", 32'(ew_red), 32'd1);
    check("rst_walk", 32'(walk), 32'd0);
    check("rst_ped", 32'(ped_pending), 32'd0);

    // Idle rest in NS green with saturated timer.
    repeat (100) step();
    check("idle_phase", 32'(phase), 32'd0);
    check("idle_timer_sat", 32'(dut.timer_q), 32'd29);

    // EW only: NS green 10, yellow 5, all-red 2, then EW rests.
    do_reset(1);
    ew_req = 1'b1;
    repeat (9) step();
    check("ew_only_ns_last", 32'(phase), 32'd0);
    step();
    check("ew_only_yellow", 32'(phase), 32'd1);
    repeat (7) step();
    check("ew_only_ewgreen", 32'(phase), 32'd3);
    repeat (40) step();
    check("ew_only_rest", 32'(phase), 32'd3);

    // Both held: 74-cycle max-out period, twice.
    ns_req = 1'b1;
    do_reset(1);
    repeat (29) step();
    check("both_ns_max_last", 32'(phase), 32'd0);
    step();
    check("both_ns_yellow", 32'(phase), 32'd1);
    repeat (44) step();
    check("both_period1", 32'(phase), 32'd0);
    repeat (74) step();
    check("both_period2", 32'(phase), 32'd0);
    check("both_period2_timer", 32'(dut.timer_q), 32'd0);

    // One-cycle ped request at cycle 3.
    ns_req = 1'b0;
    ew_req = 1'b0;
    do_reset(1);
    repeat (3) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped_latched", 32'(ped_pending), 32'd1);
    repeat (13) step();
    check("ped_walk_entry", 32'(phase), 32'd6);
    check("ped_walk_lamp", 32'(walk), 32'd1);
    check("ped_cleared", 32'(ped_pending), 32'd0);
    repeat (8) step();
    check("ped_then_ew", 32'(phase), 32'd3);

    // Reset in the 4th walk cycle, with ped_req held through the walk.
    do_reset(1);
    repeat (3) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    repeat (13) step();
    check("walk2_entry", 32'(phase), 32'd6);
    ped_req = 1'b1;
    repeat (3) step();
    check("walk2_no_relatch", 32'(ped_pending), 32'd0);
    reset = 1'b0;
    step();
    reset   = 1'b1;
    ped_req = 1'b0;
    check("walk_rst_phase", 32'(phase), 32'd0);
    check("walk_rst_walk", 32'(walk), 32'd0);
    check("walk_rst_ped", 32'(ped_pending), 32'd0);
    check("walk_rst_nsg", 32'(ns_green), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ns_req = ~ns_req;
      if ($urandom_range(0, 15) == 0) ew_req = ~ew_req;
      ped_req = ($urandom_range(0, 40) == 0);
      reset   = ($urandom_range(0, 499) != 0);
      step();
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
